// File: rtl/id_ex_operand_reg.sv
`default_nettype none
// ============================================================================
//  Module      : id_ex_operand_reg
//  Description : ID/EX pipeline register with operand forwarding for the
//                32-bit ALU. The register captures the decoded operands, the
//                immediate and the ALU control from ID. It supports stall
//                (hold) and flush (bubble). EX/MEM and MEM/WB results are
//                forwarded onto src1/src2. A saturating counter tracks the
//                number of bubble cycles.
//  Ports       : clk_i/rst_i       clock, synchronous active-low reset
//                stall_i/flush_i   hold / bubble insertion (flush wins)
//                valid_i, *_data_i, imm_i, alu_*_i, *_addr_i, reg_write_i
//                                  ID-stage fields
//                exmem_*/memwb_*   live forwarding sources
//                src1_o/src2_o     ALU operands
//                ctrl_o, rd_addr_o, reg_write_o, valid_o
//                                  stored fields passed to EX
//                fwd_a_o/fwd_b_o   forward selects (10 EX/MEM, 01 MEM/WB)
//                bubble_cnt_o      saturating bubble-cycle counter
//  Revision    : 1.0 - initial release
// ============================================================================
module id_ex_operand_reg #(
    parameter int DW   = 32,
    parameter int CNTW = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic            valid_i,
    input  logic [DW-1:0]   rs_data_i,
    input  logic [DW-1:0]   rt_data_i,
    input  logic [DW-1:0]   imm_i,
    input  logic            alu_src_i,
    input  logic [3:0]      alu_ctrl_i,
    input  logic [4:0]      rs_addr_i,
    input  logic [4:0]      rt_addr_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            reg_write_i,
    input  logic            exmem_reg_write_i,
    input  logic [4:0]      exmem_rd_i,
    input  logic [DW-1:0]   exmem_result_i,
    input  logic            memwb_reg_write_i,
    input  logic [4:0]      memwb_rd_i,
    input  logic [DW-1:0]   memwb_result_i,
    output logic [DW-1:0]   src1_o,
    output logic [DW-1:0]   src2_o,
    output logic [3:0]      ctrl_o,
    output logic [4:0]      rd_addr_o,
    output logic            reg_write_o,
    output logic            valid_o,
    output logic [1:0]      fwd_a_o,
    output logic [1:0]      fwd_b_o,
    output logic [CNTW-1:0] bubble_cnt_o
);

    // ALU control value that makes the ALU output 0; used for bubbles.
    localparam logic [3:0]      c_bubble_ctrl = 4'b1111;
    localparam logic [CNTW-1:0] c_cnt_max     = {CNTW{1'b1}};

    localparam logic [1:0] c_fwd_reg   = 2'b00;
    localparam logic [1:0] c_fwd_exmem = 2'b10;
    localparam logic [1:0] c_fwd_memwb = 2'b01;

    // Stored pipeline fields
    logic            r_valid;
    logic            r_reg_write;
    logic            r_alu_src;
    logic [3:0]      r_ctrl;
    logic [4:0]      r_rs_addr;
    logic [4:0]      r_rt_addr;
    logic [4:0]      r_rd_addr;
    logic [DW-1:0]   r_rs_data;
    logic [DW-1:0]   r_rt_data;
    logic [DW-1:0]   r_imm;
    logic [CNTW-1:0] r_bubble_cnt;

    logic [1:0]      w_fwd_a;
    logic [1:0]      w_fwd_b;
    logic [DW-1:0]   w_opa;
    logic [DW-1:0]   w_opb;

    // ------------------------------------------------------------------------
    // Pipeline register. An invalid ID instruction is stored as a bubble so
    // that nothing downstream (including forwarding) can see stale fields.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_i || flush_i || (!stall_i && !valid_i)) begin
            r_valid     <= 1'b0;
            r_reg_write <= 1'b0;
            r_alu_src   <= 1'b0;
            r_ctrl      <= c_bubble_ctrl;
            r_rs_addr   <= 5'd0;
            r_rt_addr   <= 5'd0;
            r_rd_addr   <= 5'd0;
            r_rs_data   <= '0;
            r_rt_data   <= '0;
            r_imm       <= '0;
        end else if (!stall_i) begin
            r_valid     <= 1'b1;
            r_reg_write <= reg_write_i;
            r_alu_src   <= alu_src_i;
            r_ctrl      <= alu_ctrl_i;
            r_rs_addr   <= rs_addr_i;
            r_rt_addr   <= rt_addr_i;
            r_rd_addr   <= rd_addr_i;
            r_rs_data   <= rs_data_i;
            r_rt_data   <= rt_data_i;
            r_imm       <= imm_i;
        end
    end

    // ------------------------------------------------------------------------
    // Bubble counter: counts edges on which the EX stage held a bubble,
    // saturating at all-ones.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            r_bubble_cnt <= '0;
        end else if (!r_valid && (r_bubble_cnt != c_cnt_max)) begin
            r_bubble_cnt <= r_bubble_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Forwarding select. EX/MEM holds the younger result, so it takes
    // priority over MEM/WB. Register 0 is hard-wired and never forwarded.
    // ------------------------------------------------------------------------
    function automatic logic [1:0] fwd_sel(
        input logic       valid,
        input logic [4:0] src_addr,
        input logic       exmem_we,
        input logic [4:0] exmem_rd,
        input logic       memwb_we,
        input logic [4:0] memwb_rd
    );
        logic [1:0] sel;
        sel = c_fwd_reg;
        if (valid) begin
            if (exmem_we && (exmem_rd != 5'd0) && (exmem_rd == src_addr)) begin
                sel = c_fwd_exmem;
            end else if (memwb_we && (memwb_rd != 5'd0) && (memwb_rd == src_addr)) begin
                sel = c_fwd_memwb;
            end
        end
        return sel;
    endfunction

    always_comb begin
        w_fwd_a = fwd_sel(r_valid, r_rs_addr, exmem_reg_write_i, exmem_rd_i,
                          memwb_reg_write_i, memwb_rd_i);
        w_fwd_b = fwd_sel(r_valid, r_rt_addr, exmem_reg_write_i, exmem_rd_i,
                          memwb_reg_write_i, memwb_rd_i);
    end

    always_comb begin
        case (w_fwd_a)
            c_fwd_exmem: w_opa = exmem_result_i;
            c_fwd_memwb: w_opa = memwb_result_i;
            default:     w_opa = r_rs_data;
        endcase
        case (w_fwd_b)
            c_fwd_exmem: w_opb = exmem_result_i;
            c_fwd_memwb: w_opb = memwb_result_i;
            default:     w_opb = r_rt_data;
        endcase
    end

    // Operand B forwarding is still resolved when the immediate is selected;
    // only the mux result is discarded.
    always_comb begin
        src1_o = '0;
        src2_o = '0;
        if (r_valid) begin
            src1_o = w_opa;
            src2_o = r_alu_src ? r_imm : w_opb;
        end
    end

    assign fwd_a_o      = w_fwd_a;
    assign fwd_b_o      = w_fwd_b;
    assign ctrl_o       = r_ctrl;
    assign rd_addr_o    = r_rd_addr;
    assign reg_write_o  = r_reg_write;
    assign valid_o      = r_valid;
    assign bubble_cnt_o = r_bubble_cnt;

endmodule
`default_nettype wire
